// File: rtl/contador_poller_if.sv
`default_nettype none
// ============================================================================
// Module   : contador_poller_if
// Purpose  : Counter read bus between the poller (initiator) and the
//            counter block (responder).
// Signals  : req      - read request, held while a read is outstanding
//            idx      - 2-bit index of the counter being read
//            valid    - responder indicates data_out is meaningful
//            data_out - counter value, DATA_W bits, unsigned
// Revision : 1.0 - initial release
// ============================================================================
interface contador_poller_if #(
   parameter int DATA_W = 5
) ();
   logic              req;
   logic [1:0]        idx;
   logic              valid;
   logic [DATA_W-1:0] data_out;

   modport master (
      output req,
      output idx,
      input  valid,
      input  data_out
   );

   modport slave (
      input  req,
      input  idx,
      output valid,
      output data_out
   );
endinterface
`default_nettype wire

// File: rtl/contador_poller.sv
`default_nettype none
// ============================================================================
// Module   : contador_poller
// Purpose  : Initiator side of the counter read interface. On an accepted
//            start it reads counters 0..3 in order, captures each value,
//            accumulates their sum, flags reads that time out and pulses done.
// Ports    : clk         - system clock, rising edge
//            reset_L     - asynchronous active-low reset
//            start       - one-cycle poll request, honoured only in IDLE
//            bus         - counter read bus (master side: req/idx out,
//                          valid/data_out in)
//            count_0..3  - captured counter values
//            total       - sum of the four captured values (DATA_W+2 bits)
//            timeout_err - bit i set when the read of counter i timed out
//            busy        - high from accepted start until done
//            done        - one-cycle pulse at poll completion
// Revision : 1.0 - initial release
// ============================================================================
module contador_poller #(
   parameter int DATA_W  = 5,
   parameter int TIMEOUT = 8,
   parameter int NUM_CNT = 4
) (
   input  wire logic              clk,
   input  wire logic              reset_L,
   input  wire logic              start,
   contador_poller_if.master      bus,
   output logic [DATA_W-1:0]      count_0,
   output logic [DATA_W-1:0]      count_1,
   output logic [DATA_W-1:0]      count_2,
   output logic [DATA_W-1:0]      count_3,
   output logic [DATA_W+1:0]      total,
   output logic [3:0]             timeout_err,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_NEXT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Last value of the wait counter before a read is declared timed out.
   localparam logic [3:0] TO_LAST  = 4'(TIMEOUT - 1);
   localparam logic [1:0] LAST_IDX = 2'(NUM_CNT - 1);

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic [1:0]          idx_q, idx_d;
   logic [DATA_W-1:0]   cnt_q [NUM_CNT];
   logic [DATA_W-1:0]   cnt_d [NUM_CNT];
   logic [DATA_W+1:0]   total_q, total_d;
   logic [3:0]          err_q, err_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [3:0]          wcnt_q, wcnt_d;

   // State and all outputs are registered together so every output is a flop.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         idx_q   <= 2'd0;
         total_q <= '0;
         err_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wcnt_q  <= 4'd0;
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         total_q <= total_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wcnt_q  <= wcnt_d;
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Next-state and next-output logic. req_d is set on the transition into
   // REQ so req is already high while the FSM sits in REQ, and cleared on the
   // transition into NEXT to give the responder a one-cycle gap.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      idx_d   = idx_q;
      total_d = total_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wcnt_d  = wcnt_q;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      case (state_q)
         S_IDLE: begin
            // done_q still high means this is the cycle right after DONE;
            // a start here coincides with the done pulse and is dropped.
            if (start && !done_q) begin
               state_d = S_REQ;
               req_d   = 1'b1;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               total_d = '0;
               err_d   = 4'd0;
               for (int i = 0; i < NUM_CNT; i++) begin
                  cnt_d[i] = '0;
               end
            end
         end
         S_REQ: begin
            req_d   = 1'b1;
            wcnt_d  = 4'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.valid) begin
               cnt_d[idx_q] = bus.data_out;
               total_d      = total_q + {2'b00, bus.data_out};
               req_d        = 1'b0;
               state_d      = S_NEXT;
            end else if (wcnt_q == TO_LAST) begin
               err_d[idx_q] = 1'b1;
               req_d        = 1'b0;
               state_d      = S_NEXT;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               req_d   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = 2'd0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.req     = req_q;
   assign bus.idx     = idx_q;
   assign count_0     = cnt_q[0];
   assign count_1     = cnt_q[1];
   assign count_2     = cnt_q[2];
   assign count_3     = cnt_q[3];
   assign total       = total_q;
   assign timeout_err = err_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_contador_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_poller
// Purpose  : Directed self-checking bench for contador_poller. A behavioural
//            responder answers each read after a per-index latency (0 = never)
//            and can inject a spurious valid while req is low during a poll.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_poller;
   localparam int DATA_W = 5;

   logic              clk = 1'b0;
   logic              reset_L;
   logic              start;
   logic [DATA_W-1:0] count_0, count_1, count_2, count_3;
   logic [DATA_W+1:0] total;
   logic [3:0]        timeout_err;
   logic              busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   // responder configuration
   int                lat  [4];
   logic [DATA_W-1:0] vals [4];
   bit                spur = 1'b0;
   int                rcnt = 0;

   contador_poller_if #(.DATA_W(DATA_W)) cif ();

   contador_poller #(
      .DATA_W  (DATA_W),
      .TIMEOUT (8),
      .NUM_CNT (4)
   ) dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .start       (start),
      .bus         (cif.master),
      .count_0     (count_0),
      .count_1     (count_1),
      .count_2     (count_2),
      .count_3     (count_3),
      .total       (total),
      .timeout_err (timeout_err),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Responder: valid rises lat[idx] cycles after req rises.
   always @(negedge clk) begin
      if (cif.req === 1'b1) begin
         cif.valid    = (lat[cif.idx] != 0) && (rcnt >= lat[cif.idx]);
         cif.data_out = cif.valid ? vals[cif.idx] : '0;
         rcnt         = rcnt + 1;
      end else begin
         rcnt         = 0;
         cif.valid    = spur && (busy === 1'b1);
         cif.data_out = cif.valid ? 5'd31 : 5'd0;
      end
   end

   // Stimulus only: pulse start, then watch ncyc cycles. Extra start pulses
   // are driven in cycles x1/x2 (0 = none).
   task automatic run_poll(input int ncyc, input int x1, input int x2,
                           output int done_cyc, output int done_cnt,
                           output int idx2_req, output int busy_cyc);
      done_cyc = 0; done_cnt = 0; idx2_req = 0; busy_cyc = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (busy === 1'b1) busy_cyc++;
         if (cif.req === 1'b1 && cif.idx === 2'd2) idx2_req++;
         start = (c == x1) || (c == x2);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      start   = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (cif.req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", cif.req); end
      n_checks++; if (cif.idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", cif.idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (count_0 !== 5'd0) begin n_fail++; $display("FAIL reset_count_0 got=%0d exp=0", count_0); end
      n_checks++; if (count_1 !== 5'd0) begin n_fail++; $display("FAIL reset_count_1 got=%0d exp=0", count_1); end
      n_checks++; if (count_2 !== 5'd0) begin n_fail++; $display("FAIL reset_count_2 got=%0d exp=0", count_2); end
      n_checks++; if (count_3 !== 5'd0) begin n_fail++; $display("FAIL reset_count_3 got=%0d exp=0", count_3); end
      n_checks++; if (total !== 7'd0) begin n_fail++; $display("FAIL reset_total got=%0d exp=0", total); end
      n_checks++; if (timeout_err !== 4'd0) begin n_fail++; $display("FAIL reset_err got=%b exp=0000", timeout_err); end
      reset_L = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_poll();
      logic       e_busy, e_done, e_req;
      logic [1:0] e_idx;
      lat  = '{1, 1, 1, 1};
      vals = '{5'd1, 5'd8, 5'd15, 5'd22};
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start  = 1'b0;
         e_busy = (c >= 1) && (c <= 13);
         e_done = (c == 14);
         e_req  = (c <= 12) && ((c % 3) != 0);
         e_idx  = (c <= 12) ? 2'((c - 1) / 3) : ((c == 13) ? 2'd3 : 2'd0);
         n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
         n_checks++; if (done !== e_done) begin n_fail++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", c, done, e_done); end
         n_checks++; if (cif.req !== e_req) begin n_fail++; $display("FAIL basic_req cyc=%0d got=%b exp=%b", c, cif.req, e_req); end
         n_checks++; if (cif.idx !== e_idx) begin n_fail++; $display("FAIL basic_idx cyc=%0d got=%0d exp=%0d", c, cif.idx, e_idx); end
      end
      n_checks++; if (count_0 !== 5'd1)  begin n_fail++; $display("FAIL basic_count_0 got=%0d exp=1", count_0); end
      n_checks++; if (count_1 !== 5'd8)  begin n_fail++; $display("FAIL basic_count_1 got=%0d exp=8", count_1); end
      n_checks++; if (count_2 !== 5'd15) begin n_fail++; $display("FAIL basic_count_2 got=%0d exp=15", count_2); end
      n_checks++; if (count_3 !== 5'd22) begin n_fail++; $display("FAIL basic_count_3 got=%0d exp=22", count_3); end
      n_checks++; if (total !== 7'd46) begin n_fail++; $display("FAIL basic_total got=%0d exp=46", total); end
      n_checks++; if (timeout_err !== 4'd0) begin n_fail++; $display("FAIL basic_err got=%b exp=0000", timeout_err); end
      repeat (3) @(negedge clk);
      n_checks++; if (count_3 !== 5'd22) begin n_fail++; $display("FAIL basic_hold_count_3 got=%0d exp=22", count_3); end
      n_checks++; if (total !== 7'd46) begin n_fail++; $display("FAIL basic_hold_total got=%0d exp=46", total); end
   endtask

   task automatic test_timeout();
      int dc, dn, i2, bc;
      lat  = '{1, 1, 0, 1};
      vals = '{5'd3, 5'd5, 5'd9, 5'd7};
      run_poll(24, 0, 0, dc, dn, i2, bc);
      n_checks++; if (dc != 21) begin n_fail++; $display("FAIL to_done_cycle got=%0d exp=21", dc); end
      n_checks++; if (dn != 1) begin n_fail++; $display("FAIL to_done_pulses got=%0d exp=1", dn); end
      n_checks++; if (i2 != 9) begin n_fail++; $display("FAIL to_idx2_req_cycles got=%0d exp=9", i2); end
      n_checks++; if (bc != 20) begin n_fail++; $display("FAIL to_busy_cycles got=%0d exp=20", bc); end
      n_checks++; if (timeout_err !== 4'b0100) begin n_fail++; $display("FAIL to_err got=%b exp=0100", timeout_err); end
      n_checks++; if (count_0 !== 5'd3) begin n_fail++; $display("FAIL to_count_0 got=%0d exp=3", count_0); end
      n_checks++; if (count_1 !== 5'd5) begin n_fail++; $display("FAIL to_count_1 got=%0d exp=5", count_1); end
      n_checks++; if (count_2 !== 5'd0) begin n_fail++; $display("FAIL to_count_2 got=%0d exp=0", count_2); end
      n_checks++; if (count_3 !== 5'd7) begin n_fail++; $display("FAIL to_count_3 got=%0d exp=7", count_3); end
      n_checks++; if (total !== 7'd15) begin n_fail++; $display("FAIL to_total got=%0d exp=15", total); end
   endtask

   task automatic test_back_to_back();
      int dc, dn, i2, bc;
      lat  = '{1, 1, 1, 1};
      vals = '{5'd31, 5'd31, 5'd31, 5'd31};
      // extra start mid-poll (cycle 5) and coincident with done (cycle 14)
      run_poll(17, 5, 14, dc, dn, i2, bc);
      n_checks++; if (dc != 14) begin n_fail++; $display("FAIL b2b_done_cycle got=%0d exp=14", dc); end
      n_checks++; if (dn != 1) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d exp=1", dn); end
      n_checks++; if (bc != 13) begin n_fail++; $display("FAIL b2b_busy_cycles got=%0d exp=13", bc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart_busy got=%b exp=0", busy); end
      n_checks++; if (total !== 7'd124) begin n_fail++; $display("FAIL b2b_total got=%0d exp=124", total); end
      n_checks++; if (count_2 !== 5'd31) begin n_fail++; $display("FAIL b2b_count_2 got=%0d exp=31", count_2); end
      n_checks++; if (timeout_err !== 4'd0) begin n_fail++; $display("FAIL b2b_err_cleared got=%b exp=0000", timeout_err); end
   endtask

   task automatic test_reset_mid_poll();
      int dc, dn, i2, bc;
      lat  = '{1, 1, 1, 1};
      vals = '{5'd4, 5'd6, 5'd2, 5'd1};
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      // cycle 5 is the WAIT cycle of read 1
      n_checks++; if (cif.req !== 1'b1 || cif.idx !== 2'd1) begin n_fail++; $display("FAIL rst_mid_pre req=%b idx=%0d exp req=1 idx=1", cif.req, cif.idx); end
      n_checks++; if (count_0 !== 5'd4) begin n_fail++; $display("FAIL rst_mid_pre_count_0 got=%0d exp=4", count_0); end
      reset_L = 1'b0;
      #1;
      n_checks++; if (cif.req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got=%b exp=0", cif.req); end
      n_checks++; if (cif.idx !== 2'd0) begin n_fail++; $display("FAIL rst_mid_idx got=%0d exp=0", cif.idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      n_checks++; if (count_0 !== 5'd0) begin n_fail++; $display("FAIL rst_mid_count_0 got=%0d exp=0", count_0); end
      n_checks++; if (total !== 7'd0) begin n_fail++; $display("FAIL rst_mid_total got=%0d exp=0", total); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done cyc=%0d got=%b exp=0", c, done); end
      end
      reset_L = 1'b1;
      @(negedge clk);
      vals = '{5'd10, 5'd11, 5'd12, 5'd13};
      run_poll(16, 0, 0, dc, dn, i2, bc);
      n_checks++; if (dc != 14) begin n_fail++; $display("FAIL rst_mid_repoll_done got=%0d exp=14", dc); end
      n_checks++; if (count_1 !== 5'd11) begin n_fail++; $display("FAIL rst_mid_repoll_count_1 got=%0d exp=11", count_1); end
      n_checks++; if (total !== 7'd46) begin n_fail++; $display("FAIL rst_mid_repoll_total got=%0d exp=46", total); end
   endtask

   task automatic test_variable_latency();
      int dc, dn, i2, bc;
      lat  = '{3, 1, 1, 1};
      vals = '{5'd9, 5'd2, 5'd0, 5'd17};
      spur = 1'b1;
      run_poll(18, 0, 0, dc, dn, i2, bc);
      spur = 1'b0;
      n_checks++; if (dc != 16) begin n_fail++; $display("FAIL varlat_done_cycle got=%0d exp=16", dc); end
      n_checks++; if (count_0 !== 5'd9)  begin n_fail++; $display("FAIL varlat_count_0 got=%0d exp=9", count_0); end
      n_checks++; if (count_1 !== 5'd2)  begin n_fail++; $display("FAIL varlat_count_1 got=%0d exp=2", count_1); end
      n_checks++; if (count_2 !== 5'd0)  begin n_fail++; $display("FAIL varlat_count_2 got=%0d exp=0", count_2); end
      n_checks++; if (count_3 !== 5'd17) begin n_fail++; $display("FAIL varlat_count_3 got=%0d exp=17", count_3); end
      n_checks++; if (total !== 7'd28) begin n_fail++; $display("FAIL varlat_total got=%0d exp=28", total); end
      n_checks++; if (timeout_err !== 4'd0) begin n_fail++; $display("FAIL varlat_err got=%b exp=0000", timeout_err); end
   endtask

   initial begin
      lat  = '{1, 1, 1, 1};
      vals = '{5'd0, 5'd0, 5'd0, 5'd0};
      test_reset();
      test_basic_poll();
      test_timeout();
      test_back_to_back();
      test_reset_mid_poll();
      test_variable_latency();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/contador_poller.md
Name: contador_poller

Overview:
- Initiator side of the counter read interface (req/idx -> valid/data_out) in the PCIe transaction layer.
- On a start pulse, it reads the four per-FIFO word counters in order, idx 0 to 3.
- It captures each count, accumulates a total, flags any read that times out, and reports done.
- It sits between the control FSM (which issues start once the layer is IDLE) and the counter block.

Parameters:
- DATA_W, 5, width of the counter value returned by the counter block.
- TIMEOUT, 8, max cycles to wait for valid after req is presented, range 1..15.
- NUM_CNT, 4, number of counters polled; fixed at 4 to match 2-bit idx.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse requesting a full poll; ignored unless in IDLE.
- valid  input  1  counter block response valid.
- data_out  input  DATA_W  counter value; meaningful only while valid=1.
- req  output  1  read request to counter block.
- idx  output  2  counter index being requested.
- count_0..count_3  output  DATA_W each  captured counter values.
- total  output  DATA_W+2  sum of the four captured counts.
- timeout_err  output  4  bit i=1 if read of counter i timed out.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the poll completes.

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE, req=0, idx=0, count_0..3=0, total=0, timeout_err=0, busy=0, done=0, wait counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: on start=1, go to REQ next cycle; clear total, timeout_err and count_0..3; set busy=1; idx=0.
  - REQ: req=1 with idx stable; load wait counter=0; go to WAIT.
  - WAIT: req held 1, idx held. On valid=1, latch data_out into count_[idx], add it to total, and go to NEXT. Otherwise increment the wait counter. When it reaches TIMEOUT-1 with valid still 0, set timeout_err[idx], leave count_[idx]=0, and go to NEXT.
  - NEXT: req=0 for exactly one cycle, so the responder sees a fresh request. If idx==3, go to DONE; else idx=idx+1 and go to REQ.
  - DONE: done=1 for one cycle, busy=0, idx=0; go to IDLE.
- Handshake:
  - The responder may return valid one or more cycles after req rises.
  - valid is sampled only in WAIT. valid in any other state is ignored and causes no capture.
  - valid in the same cycle the FSM enters WAIT counts as a response, so minimum latency is 1 cycle after req.
- Latency with a 1-cycle responder: start to done pulse = 1 + 4×3 + 1 = 14 cycles.
- Arithmetic:
  - total is an unsigned DATA_W+2 bit sum and cannot overflow (max 4×31=124 < 128).
  - data_out is taken as unsigned.
- Boundary conditions:
  - start while busy: ignored; no restart.
  - start coincident with done: ignored; a new start is needed in IDLE.
  - Reset mid-poll: immediate return to reset values; partial counts are discarded; no done pulse.
  - TIMEOUT=1: timeout fires in the first WAIT cycle if valid=0.
  - Captured values and timeout_err hold stable from done until the next accepted start.

Test Plan:
1. Reset then start; responder returns counts 1, 8, 15, 22 (valid 1 cycle after req) -> req/idx sequence 0,1,2,3 with a req=0 gap cycle between reads; count_0..3=1,8,15,22; total=46; timeout_err=0; done pulses at cycle 14 after start; busy high for cycles 1..13.
2. Responder never asserts valid for idx=2; TIMEOUT=8 -> idx=2 held 8 WAIT cycles; timeout_err=4'b0100; count_2=0; remaining counts captured; done still asserted.
3. All counters return 31 -> total=124, no wrap; pulse start again during the poll -> ignored, single done pulse.
4. Assert reset_L=0 while in WAIT for idx=1 -> req=0, idx=0, busy=0, count/total/timeout_err cleared asynchronously; a later start performs a full clean poll.
5. Responder with variable latency (3 cycles for idx=0, 1 cycle for the others), plus a spurious valid while in NEXT -> correct per-index capture; the spurious valid does not alter counts.
